// File: rtl/hpi_pkg.sv
// ============================================================================
//  Module   : hpi_pkg
//  Purpose  : Shared register map and status bit layout for the HPI target.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hpi_pkg;

    typedef enum logic [1:0] {
        DATA    = 2'd0,
        MAILBOX = 2'd1,
        ADDRESS = 2'd2,
        STATUS  = 2'd3
    } hpi_reg_e;

    localparam int STAT_OUT_FULL = 0;
    localparam int STAT_IN_FULL  = 1;
    localparam int STAT_OVF      = 2;

endpackage

`default_nettype wire

// File: rtl/hpi_strobe_sync.sv
// ============================================================================
//  Module   : hpi_strobe_sync
//  Purpose  : Two-stage capture of the HPI pins with strobe edge detection.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hpi_strobe_sync (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        i_cs_n,
    input  logic        i_rd_n,
    input  logic        i_wr_n,
    input  logic [1:0]  i_addr,
    input  logic [15:0] i_data,
    output logic        o_cs1_n,
    output logic        o_rd1_n,
    output logic        o_wr1_n,
    output logic [1:0]  o_addr1,
    output logic        o_cs2_n,
    output logic        o_rd2_n,
    output logic        o_wr2_n,
    output logic [1:0]  o_addr2,
    output logic [15:0] o_data2,
    output logic        o_rd_fall,
    output logic        o_rd_rise,
    output logic        o_wr_rise
);

    logic        r_cs1_n, r_rd1_n, r_wr1_n;
    logic        r_cs2_n, r_rd2_n, r_wr2_n;
    logic [1:0]  r_addr1, r_addr2;
    logic [15:0] r_data1, r_data2;

    // Strobes idle high out of reset so no spurious edge is seen on release.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_cs1_n <= 1'b1;
            r_rd1_n <= 1'b1;
            r_wr1_n <= 1'b1;
            r_cs2_n <= 1'b1;
            r_rd2_n <= 1'b1;
            r_wr2_n <= 1'b1;
            r_addr1 <= 2'd0;
            r_addr2 <= 2'd0;
            r_data1 <= 16'd0;
            r_data2 <= 16'd0;
        end else begin
            r_cs1_n <= i_cs_n;
            r_rd1_n <= i_rd_n;
            r_wr1_n <= i_wr_n;
            r_addr1 <= i_addr;
            r_data1 <= i_data;
            r_cs2_n <= r_cs1_n;
            r_rd2_n <= r_rd1_n;
            r_wr2_n <= r_wr1_n;
            r_addr2 <= r_addr1;
            r_data2 <= r_data1;
        end
    end

    assign o_cs1_n   = r_cs1_n;
    assign o_rd1_n   = r_rd1_n;
    assign o_wr1_n   = r_wr1_n;
    assign o_addr1   = r_addr1;
    assign o_cs2_n   = r_cs2_n;
    assign o_rd2_n   = r_rd2_n;
    assign o_wr2_n   = r_wr2_n;
    assign o_addr2   = r_addr2;
    assign o_data2   = r_data2;
    assign o_rd_fall = r_rd2_n & ~r_rd1_n;
    assign o_rd_rise = ~r_rd2_n & r_rd1_n;
    assign o_wr_rise = ~r_wr2_n & r_wr1_n;

endmodule

`default_nettype wire

// File: rtl/hpi_target_port.sv
// ============================================================================
//  Module   : hpi_target_port
//  Purpose  : HPI responder with shared memory, mailboxes and status register.
//             Define HPI_AUTOINC_EN to auto-increment the pointer on DATA access.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hpi_target_port
    import hpi_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic              Clk,
    input  logic              Reset_N,
    inout  wire  [15:0]       OTG_DATA,
    input  logic [1:0]        OTG_ADDR,
    input  logic              OTG_CS_N,
    input  logic              OTG_RD_N,
    input  logic              OTG_WR_N,
    input  logic              OTG_RST_N,
    output logic              OTG_INT,
    input  logic [MEM_AW-1:0] loc_addr,
    input  logic [15:0]       loc_wdata,
    input  logic              loc_we,
    output logic [15:0]       loc_rdata,
    input  logic [15:0]       loc_mbx_wdata,
    input  logic              loc_mbx_we,
    output logic [15:0]       loc_mbx_rdata,
    output logic              loc_mbx_valid,
    input  logic              loc_mbx_ack
);

    logic              w_cs1_n, w_rd1_n, w_wr1_n;
    logic              w_cs2_n, w_rd2_n, w_wr2_n;
    logic [1:0]        w_addr1, w_addr2;
    logic [15:0]       w_data2;
    logic              w_rd_fall, w_rd_rise, w_wr_rise;

    logic [15:0]       r_mem [MEM_WORDS];
    logic [MEM_AW-1:0] r_ptr;
    logic [15:0]       r_mbx_out;
    logic              r_out_full;
    logic              r_ovf;
    logic [15:0]       r_rd_data;
    logic              r_drive;

    logic              w_wr_commit, w_rd_start, w_rd_done;
    logic              w_mem_hpi_we;
    hpi_reg_e          w_reg1, w_reg2;
    logic [15:0]       w_status;
    logic [15:0]       w_ptr_byte;

    hpi_strobe_sync u_sync (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .i_cs_n    (OTG_CS_N),
        .i_rd_n    (OTG_RD_N),
        .i_wr_n    (OTG_WR_N),
        .i_addr    (OTG_ADDR),
        .i_data    (OTG_DATA),
        .o_cs1_n   (w_cs1_n),
        .o_rd1_n   (w_rd1_n),
        .o_wr1_n   (w_wr1_n),
        .o_addr1   (w_addr1),
        .o_cs2_n   (w_cs2_n),
        .o_rd2_n   (w_rd2_n),
        .o_wr2_n   (w_wr2_n),
        .o_addr2   (w_addr2),
        .o_data2   (w_data2),
        .o_rd_fall (w_rd_fall),
        .o_rd_rise (w_rd_rise),
        .o_wr_rise (w_wr_rise)
    );

    assign w_reg1 = hpi_reg_e'(w_addr1);
    assign w_reg2 = hpi_reg_e'(w_addr2);

    // Overlapping RD_N/WR_N cycles are illegal: each strobe edge requires the other idle.
    assign w_wr_commit  = w_wr_rise & ~w_cs2_n & w_rd2_n;
    assign w_rd_start   = w_rd_fall & ~w_cs1_n & w_wr1_n;
    assign w_rd_done    = w_rd_rise & ~w_cs2_n & w_wr2_n;
    assign w_mem_hpi_we = w_wr_commit && (w_reg2 == DATA);

    assign w_ptr_byte = 16'({r_ptr, 1'b0});

    always_comb begin
        w_status                = 16'd0;
        w_status[STAT_OUT_FULL] = r_out_full;
        w_status[STAT_IN_FULL]  = loc_mbx_valid;
        w_status[STAT_OVF]      = r_ovf;
    end

    // Later assignment wins, so an HPI write beats a local write to the same word.
    always_ff @(posedge Clk) begin
        if (loc_we) begin
            r_mem[loc_addr] <= loc_wdata;
        end
        if (w_mem_hpi_we) begin
            r_mem[r_ptr] <= w_data2;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_ptr         <= '0;
            r_mbx_out     <= 16'd0;
            r_out_full    <= 1'b0;
            r_ovf         <= 1'b0;
            r_rd_data     <= 16'd0;
            r_drive       <= 1'b0;
            loc_rdata     <= 16'd0;
            loc_mbx_rdata <= 16'd0;
            loc_mbx_valid <= 1'b0;
        end else if (!OTG_RST_N) begin
            r_ptr         <= '0;
            r_mbx_out     <= 16'd0;
            r_out_full    <= 1'b0;
            r_ovf         <= 1'b0;
            r_rd_data     <= 16'd0;
            r_drive       <= 1'b0;
            loc_rdata     <= 16'd0;
            loc_mbx_rdata <= 16'd0;
            loc_mbx_valid <= 1'b0;
        end else begin
            loc_rdata <= r_mem[loc_addr];

            if (w_wr_commit && (w_reg2 == ADDRESS)) begin
                r_ptr <= w_data2[MEM_AW:1];
            end
`ifdef HPI_AUTOINC_EN
            else if ((w_wr_commit || w_rd_done) && (w_reg2 == DATA)) begin
                r_ptr <= r_ptr + MEM_AW'(1);
            end
`endif

            if (w_rd_start) begin
                case (w_reg1)
                    DATA:    r_rd_data <= r_mem[r_ptr];
                    MAILBOX: r_rd_data <= r_mbx_out;
                    ADDRESS: r_rd_data <= w_ptr_byte;
                    default: r_rd_data <= w_status;
                endcase
            end

            // Drive only once the read data has been latched and the strobe is still held.
            if (w_rd_start) begin
                r_drive <= 1'b1;
            end else if (w_cs1_n || w_rd1_n || !w_wr1_n) begin
                r_drive <= 1'b0;
            end

            if (loc_mbx_we) begin
                r_mbx_out  <= loc_mbx_wdata;
                r_out_full <= 1'b1;
                if (r_out_full) begin
                    r_ovf <= 1'b1;
                end
            end else if (w_rd_done && (w_reg2 == MAILBOX)) begin
                r_out_full <= 1'b0;
            end

            if (w_wr_commit && (w_reg2 == MAILBOX)) begin
                loc_mbx_rdata <= w_data2;
                loc_mbx_valid <= 1'b1;
            end else if (loc_mbx_ack) begin
                loc_mbx_valid <= 1'b0;
            end
        end
    end

    assign OTG_INT  = r_out_full;
    assign OTG_DATA = (r_drive && !w_cs1_n && !w_rd1_n && w_wr1_n) ? r_rd_data : 16'hzzzz;

endmodule

`default_nettype wire
